// File: rtl/matrix_pkg.sv
// ============================================================================
//  Module   : matrix_pkg
//  Purpose  : Register map, status codes and RAM layout shared by matrix DMAs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

    localparam int unsigned MAX_DIM    = 32;
    localparam int unsigned RAM_STRIDE = 32;
    localparam int unsigned RAM_ADDR_W = 10;

    localparam logic REG_PTR    = 1'b0;
    localparam logic REG_RESULT = 1'b0;
    localparam logic REG_LEN    = 1'b1;
    localparam logic REG_STATUS = 1'b1;

    localparam logic STATUS_READY = 1'b0;
    localparam logic STATUS_BUSY  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } wb_state_t;

    function automatic logic [RAM_ADDR_W-1:0] rowcol_addr(input logic [4:0] row,
                                                          input logic [4:0] col);
        return RAM_ADDR_W'(row) * RAM_ADDR_W'(RAM_STRIDE) + RAM_ADDR_W'(col);
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_writeback_wb_fifo.sv
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : Two-entry 32-bit FIFO decoupling RAM read data from bus stalls.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [31:0] i_data,
    output logic [31:0] o_head,
    output logic        o_empty,
    output logic        o_full,
    output logic [1:0]  o_count
);

    logic [31:0] r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= 32'd0;
            r_mem[1] <= 32'd0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_writeback.sv
// ============================================================================
//  Module   : matrix_writeback
//  Purpose  : Avalon-MM write-master DMA streaming the NxN matrix RAM to memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_writeback
    import matrix_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_slave_address,
    input  logic [31:0] i_slave_writedata,
    input  logic        i_slave_write,
    input  logic        i_slave_read,
    output logic [31:0] o_slave_readdata,
    output logic        o_slave_waitrequest,
    output logic        o_irq,
    output logic [29:0] o_address,
    output logic        o_write,
    output logic [31:0] o_writedata,
    input  logic        i_waitrequest,
    output logic [9:0]  o_ram_addr,
    input  logic [31:0] i_ram_q
);

    wb_state_t   r_state;
    wb_state_t   w_next;
    logic [31:0] r_ptr;
    logic [31:0] r_addr;
    logic [5:0]  r_len;
    logic [4:0]  r_row;
    logic [4:0]  r_col;
    logic        r_rd_done;
    logic        r_rd_vld;
    logic [10:0] r_words;
    logic        r_irq;

    logic [5:0]  w_len;
    logic        w_start;
    logic [10:0] w_total;
    logic [4:0]  w_last_idx;
    logic        w_accept;
    logic        w_last_accept;
    logic        w_issue;
    logic [2:0]  w_slots_used;
    logic        w_irq_set;
    logic        w_status;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic [1:0]  w_fifo_count;

    assign w_len         = i_slave_writedata[5:0];
    assign w_start       = i_slave_write && (i_slave_address == REG_LEN)
                           && (r_state == S_IDLE) && (32'(w_len) <= MAX_DIM);
    assign w_total       = 11'(r_len) * 11'(r_len);
    assign w_last_idx    = r_len[4:0] - 5'd1;
    assign w_accept      = o_write && !i_waitrequest;
    assign w_last_accept = w_accept && (r_words == w_total - 11'd1);
    // A slot freed by this cycle's acceptance may be refilled immediately.
    assign w_slots_used  = {1'b0, w_fifo_count} + {2'b0, r_rd_vld};
    assign w_issue       = (r_state == S_RUN) && !r_rd_done
                           && (w_slots_used < (w_accept ? 3'd3 : 3'd2));
    assign w_irq_set     = ((r_state == S_RUN) && w_last_accept)
                           || ((r_state == S_DONE) && (r_len == 6'd0));
    assign w_status      = (r_state == S_RUN) ? STATUS_BUSY : STATUS_READY;

    assign o_slave_waitrequest = 1'b0;
    assign o_slave_readdata    = (i_slave_address == REG_RESULT) ? {21'd0, r_words}
                                                                 : {31'd0, w_status};
    assign o_irq      = r_irq;
    assign o_address  = r_addr[29:0];
    assign o_write    = !w_fifo_empty;
    assign o_ram_addr = rowcol_addr(r_row, r_col);

    wb_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_vld),
        .i_pop   (w_accept),
        .i_data  (i_ram_q),
        .o_head  (o_writedata),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = (w_len == 6'd0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last_accept) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= 32'd0;
            r_addr    <= 32'd0;
            r_len     <= 6'd0;
            r_row     <= 5'd0;
            r_col     <= 5'd0;
            r_rd_done <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_words   <= 11'd0;
            r_irq     <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (i_slave_write && (i_slave_address == REG_PTR)) begin
                r_ptr <= i_slave_writedata;
            end
            if (w_start) begin
                r_len     <= w_len;
                r_row     <= 5'd0;
                r_col     <= 5'd0;
                r_rd_done <= 1'b0;
                r_addr    <= r_ptr;
                r_words   <= 11'd0;
            end else begin
                // The read pointer parks on the final element instead of running past it.
                if (w_issue) begin
                    if (r_col == w_last_idx) begin
                        if (r_row == w_last_idx) begin
                            r_rd_done <= 1'b1;
                        end else begin
                            r_row <= r_row + 5'd1;
                            r_col <= 5'd0;
                        end
                    end else begin
                        r_col <= r_col + 5'd1;
                    end
                end
                if (w_accept) begin
                    r_addr  <= r_addr + 32'd4;
                    r_words <= r_words + 11'd1;
                end
            end
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (i_slave_read) begin
                r_irq <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
